proc_control: RTL and testbench
===============================

// Module: proc_control
// PURPOSE
//  Control FSM of the 16-bit multicycle processor. Fetches a 9-bit instruction from din into an internal IR.
//  Sequences each instruction in 2 or 4 steps (T0..T3).
//  Drives the bus-select enables (r_out/din_out/g_out) that feed the bus multiplexer directly downstream.
//  Also drives the register/A/G write enables and the ALU op code.
// PARAMETERS
//  IR_W    9  instruction width, format III_XXX_YYY (opcode, Rx, Ry)
//  NREGS   8  number of general registers (fixed 8; 3-bit fields)
// PORTS
//  clock    in   1   single system clock, all state on rising edge
//  reset    in   1   synchronous, active-high
//  run      in   1   start request, sampled only in T0
//  din      in   16  external data bus; IR loads din[8:0] in T0
//  g_nz     in   1   1 when G register != 0 (used by mvnz only)
//  r_out    out  8   one-hot bus select, bit i -> Ri onto bus
//  din_out  out  1   din onto bus
//  g_out    out  1   G onto bus
//  r_in     out  8   register write enables, bit i -> Ri
//  a_in     out  1   A register write enable
//  g_in     out  1   G register write enable
//  alu_op   out  3   ALU function: 0 add, 1 sub, 2 and, 3 or, 4 slt
//  done     out  1   one-cycle pulse on last step of an instruction
//  ir_q     out  9   current IR contents (debug/observation)
// BEHAVIOUR
//  - Reset is synchronous, active-high. Next state is T0 and ir_q = 0.
//    All outputs are 0 in the reset cycle and in idle T0.
//  - State register: T0..T3, 2-bit. Outputs are combinational from (state, ir_q, run, g_nz).
//  - T0, run=0: stay in T0, no enables asserted.
//  - T0, run=1: ir_in internal; ir_q <= din[8:0] at the edge; go to T1.
//  - Opcodes (X = ir_q[5:3], Y = ir_q[2:0]):
//    000 mv  X,Y   T1: r_out[Y], r_in[X], done -> T0
//    001 mvi X,#D  T1: din_out, r_in[X], done -> T0
//                  (immediate word presented on din in T1)
//    010 add, 011 sub, 100 and, 101 or, 110 slt:
//                  T1: r_out[X], a_in -> T2
//                  T2: r_out[Y], g_in, alu_op -> T3
//                  T3: g_out, r_in[X], done -> T0
//    111 (see CONFIGURATION)
//  - alu_op is held at the decoded value during T2 and T3. alu_op = 0 otherwise.
//  - Invariant: at most one of {r_out[7:0], din_out, g_out} is high in any cycle.
//    Any bus select being high implies done or a register/A/G write in the same cycle.
//  - run is ignored in T1..T3. run held high in the done cycle starts the next fetch in the following T0.
//  - X==Y is legal (e.g. add R3,R3 doubles R3). No special case.
//  - Reset mid-instruction (any of T1..T3): no enables asserted in that cycle.
//    Next cycle is T0 and the interrupted instruction is abandoned.
//  - Latency, run accepted to done: 2 cycles for mv/mvi/mvnz, 4 cycles for ALU ops.
// CONFIGURATION
//  Macro PROC_CTRL_MVNZ_EN:
//  - Defined: opcode 111 = mvnz X,Y. T1 asserts r_out[Y] and done, plus r_in[X] only if g_nz=1; then T0.
//  - Not defined: opcode 111 is a NOP. T1 asserts done only, no bus select, no write; g_nz is unused.
// STRUCTURE
//  - Shared header proc_defs.vh holds:
//    opcode localparams (OP_MV..OP_MVNZ); state codes T0..T3; ALU_ADD..ALU_SLT codes; bus width 16.
//    This header is also used by the ALU and the testbench.
//  - Sub-module dec3to8: 3-bit field to 8-bit one-hot with enable. Two instances (X and Y fields).
// TESTING
//  - Reset/idle: reset=1 2 cycles, then run=0 10 cycles -> state T0, all outputs 0, ir_q=0.
//  - mvi: run=1, din=9'b001_010_000 then din=16'h00A5 in T1
//    -> T1 shows din_out=1, r_in=8'h04, done=1; back to T0.
//  - add R1,R2 (9'b010_001_010):
//    T1 r_out=8'h02, a_in=1
//    T2 r_out=8'h04, g_in=1, alu_op=0
//    T3 g_out=1, r_in=8'h02, done=1
//    done occurs exactly 4 cycles after run is accepted.
//  - mvnz R0,R7 (9'b111_000_111) with PROC_CTRL_MVNZ_EN:
//    g_nz=0 -> r_out=8'h80, r_in=0, done=1
//    g_nz=1 -> r_in=8'h01
//    Without the macro: done=1 and no other enables.
//  - Reset asserted in T2 of sub -> no g_in in that cycle; T0 next cycle with r_in=0; new instruction then runs normally.
//  - Back-to-back: run held high across mv, slt, mvi -> done pulses at cycles 2, 6, 8.
//    The one-hot bus-select assertion holds on every cycle.

Source files
------------

// File: rtl/proc_control_pkg.sv
// Shared definitions for the multicycle processor control path: field widths,
// opcode/step/ALU encodings, the instruction register layout and small decode
// helpers used by the controller.
package proc_control_pkg;

    localparam int BUS_W = 16;  // external data bus width
    localparam int IR_W  = 9;   // instruction width, III_XXX_YYY
    localparam int NREGS = 8;   // general registers R0..R7

    typedef enum logic [2:0] {
        OP_MV   = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_SLT  = 3'b110,
        OP_MVNZ = 3'b111
    } opcode_e;

    // Instruction step counter; T0 doubles as the idle/fetch step.
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    // Instruction register layout: opcode, destination Rx, source Ry.
    typedef struct packed {
        opcode_e    op;
        logic [2:0] rx;
        logic [2:0] ry;
    } instr_t;

    // True for the two-operand ALU instructions that take the T1..T3 path.
    function automatic logic is_alu_op(input opcode_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT};
    endfunction

    // ALU function selected by an ALU-class opcode (add for anything else).
    function automatic alu_op_e alu_code(input opcode_e op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/proc_control_if.sv
// Bundle of the controller's handshake, data-in and control-out signals.
// The slave modport is the controller; the master modport is the datapath
// (or a testbench standing in for it).
interface proc_control_if;
    import proc_control_pkg::*;

    logic             run;      // start request, sampled only in T0
    logic [BUS_W-1:0] din;      // external data bus
    logic             g_nz;     // G register is non-zero
    logic [NREGS-1:0] r_out;    // one-hot register bus select
    logic             din_out;  // din onto bus
    logic             g_out;    // G onto bus
    logic [NREGS-1:0] r_in;     // register write enables
    logic             a_in;     // A register write enable
    logic             g_in;     // G register write enable
    logic [2:0]       alu_op;   // ALU function code
    logic             done;     // last step of an instruction
    logic [IR_W-1:0]  ir_q;     // current instruction register

    modport slave (
        input  run, din, g_nz,
        output r_out, din_out, g_out, r_in, a_in, g_in, alu_op, done, ir_q
    );

    modport master (
        output run, din, g_nz,
        input  r_out, din_out, g_out, r_in, a_in, g_in, alu_op, done, ir_q
    );

endinterface

// File: rtl/proc_control_dec3to8.sv
// 3-bit register field to 8-bit one-hot select, forced to zero when disabled.
module dec3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] onehot
);

    // One-hot decode of the selected register number.
    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (which would infer a latch).
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_control.sv
// Control FSM of the 16-bit multicycle processor.
// Fetches a 9-bit instruction from din in T0 and sequences it in T1..T3,
// driving the bus-select enables, register/A/G write enables and ALU op.
// Optional feature macro: PROC_CTRL_MVNZ_EN (opcode 111 = mvnz X,Y; NOP otherwise).
module proc_control
    import proc_control_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    proc_control_if.slave  bus
);

    step_e            state;
    instr_t           ir;
    logic [NREGS-1:0] x_oh;
    logic [NREGS-1:0] y_oh;
    logic             active;
    logic             unused_bits;

    // Combinational enables; registers only hold step and instruction.
    logic [NREGS-1:0] r_out_c;
    logic             din_out_c;
    logic             g_out_c;
    logic [NREGS-1:0] r_in_c;
    logic             a_in_c;
    logic             g_in_c;
    alu_op_e          alu_op_c;
    logic             done_c;

    // A reset cycle drives no enables, even mid-instruction.
    assign active = ~reset;

    dec3to8 u_dec_x (
        .en     (active),
        .sel    (ir.rx),
        .onehot (x_oh)
    );

    dec3to8 u_dec_y (
        .en     (active),
        .sel    (ir.ry),
        .onehot (y_oh)
    );

    // Step sequencer and instruction fetch; run is only looked at in T0.
    always_ff @(posedge clock) begin
        // NOTE: sequential state is updated with non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state <= T0;
            ir    <= '0;
        end else begin
            case (state)
                T0: begin
                    if (bus.run) begin
                        ir    <= instr_t'(bus.din[IR_W-1:0]);
                        state <= T1;
                    end
                end
                T1:      state <= is_alu_op(ir.op) ? T2 : T0;
                T2:      state <= T3;
                T3:      state <= T0;
                default: state <= T0;
            endcase
        end
    end

    // Per-step enable decode from the current step and instruction.
    always_comb begin
        r_out_c   = '0;
        din_out_c = 1'b0;
        g_out_c   = 1'b0;
        r_in_c    = '0;
        a_in_c    = 1'b0;
        g_in_c    = 1'b0;
        alu_op_c  = ALU_ADD;
        done_c    = 1'b0;
        if (active) begin
            case (state)
                T1: begin
                    case (ir.op)
                        OP_MV: begin
                            r_out_c = y_oh;
                            r_in_c  = x_oh;
                            done_c  = 1'b1;
                        end
                        OP_MVI: begin
                            // Immediate word is on din during this step.
                            din_out_c = 1'b1;
                            r_in_c    = x_oh;
                            done_c    = 1'b1;
                        end
                        OP_MVNZ: begin
`ifdef PROC_CTRL_MVNZ_EN
                            // Ry is always put on the bus; the write is conditional.
                            r_out_c = y_oh;
                            if (bus.g_nz) begin
                                r_in_c = x_oh;
                            end
`endif
                            done_c = 1'b1;
                        end
                        default: begin
                            // ALU op: first operand Rx into A.
                            r_out_c = x_oh;
                            a_in_c  = 1'b1;
                        end
                    endcase
                end
                T2: begin
                    // Second operand Ry through the ALU into G.
                    r_out_c  = y_oh;
                    g_in_c   = 1'b1;
                    alu_op_c = alu_code(ir.op);
                end
                T3: begin
                    // Result from G back into Rx.
                    g_out_c  = 1'b1;
                    r_in_c   = x_oh;
                    alu_op_c = alu_code(ir.op);
                    done_c   = 1'b1;
                end
                default: begin
                    // T0: fetch or idle, nothing enabled.
                end
            endcase
        end
    end

    assign bus.r_out   = r_out_c;
    assign bus.din_out = din_out_c;
    assign bus.g_out   = g_out_c;
    assign bus.r_in    = r_in_c;
    assign bus.a_in    = a_in_c;
    assign bus.g_in    = g_in_c;
    assign bus.alu_op  = alu_op_c;
    assign bus.done    = done_c;
    assign bus.ir_q    = ir;

    // Upper din bits never reach the controller; g_nz only matters with mvnz.
`ifdef PROC_CTRL_MVNZ_EN
    assign unused_bits = ^bus.din[BUS_W-1:IR_W];
`else
    assign unused_bits = ^{bus.din[BUS_W-1:IR_W], bus.g_nz};
`endif

endmodule

// File: tb/tb_proc_control.sv
// Self-checking bench for proc_control: directed scenarios followed by random
// stimulus, all compared against a queue-of-steps reference model.
// Honours PROC_CTRL_MVNZ_EN the same way the design does.
module tb_proc_control;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    proc_control_if bus_if ();

    proc_control dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    // Expected control word for one cycle.
    typedef struct packed {
        logic [7:0] r_out;
        logic       din_out;
        logic       g_out;
        logic [7:0] r_in;
        logic       a_in;
        logic       g_in;
        logic [2:0] alu_op;
        logic       done;
    } ctl_t;

    // One planned step; cond marks a write that depends on g_nz in that cycle.
    typedef struct packed {
        ctl_t       v;
        logic       cond;
        logic [7:0] cond_r_in;
    } step_t;

    step_t      plan_q[$];
    logic [8:0] m_ir;
    bit         ir_known = 1'b0;
    int         cyc = 0;
    int         accept_cyc = 0;
    int         done_log[$];
    int         n_checks = 0;
    int         n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expand an instruction into the list of steps that follow its fetch.
    function automatic void plan(input logic [8:0] ins);
        logic [2:0] op = ins[8:6];
        logic [7:0] xs = 8'd1 << ins[5:3];
        logic [7:0] ys = 8'd1 << ins[2:0];
        step_t s;
        s = '0;
        if (op == 3'd0) begin
            s.v.r_out = ys; s.v.r_in = xs; s.v.done = 1'b1;
            plan_q.push_back(s);
        end else if (op == 3'd1) begin
            s.v.din_out = 1'b1; s.v.r_in = xs; s.v.done = 1'b1;
            plan_q.push_back(s);
        end else if (op == 3'd7) begin
`ifdef PROC_CTRL_MVNZ_EN
            s.v.r_out = ys; s.cond = 1'b1; s.cond_r_in = xs;
`endif
            s.v.done = 1'b1;
            plan_q.push_back(s);
        end else begin
            s.v.r_out = xs; s.v.a_in = 1'b1;
            plan_q.push_back(s);
            s = '0;
            s.v.r_out = ys; s.v.g_in = 1'b1; s.v.alu_op = op - 3'd2;
            plan_q.push_back(s);
            s = '0;
            s.v.g_out = 1'b1; s.v.r_in = xs; s.v.alu_op = op - 3'd2; s.v.done = 1'b1;
            plan_q.push_back(s);
        end
    endfunction

    // One clock cycle: drive, predict, compare mid-cycle, then advance the model.
    // Entered and left 1 time unit after a rising edge.
    task automatic cycle(input string tag, input logic rst_i, input logic run_i,
                         input logic [15:0] din_i, input logic gnz_i);
        ctl_t exp_v;
        ctl_t got_v;
        int   sel_cnt;
        reset       = rst_i;
        bus_if.run  = run_i;
        bus_if.din  = din_i;
        bus_if.g_nz = gnz_i;
        cyc++;
        exp_v = '0;
        if (!rst_i && plan_q.size() != 0) begin
            exp_v = plan_q[0].v;
            if (plan_q[0].cond && gnz_i) exp_v.r_in = plan_q[0].cond_r_in;
        end
        @(negedge clock);
        got_v = {bus_if.r_out, bus_if.din_out, bus_if.g_out, bus_if.r_in,
                 bus_if.a_in, bus_if.g_in, bus_if.alu_op, bus_if.done};
        check({tag, "_ctl"}, 32'(got_v), 32'(exp_v));
        if (ir_known) check({tag, "_ir_q"}, 32'(bus_if.ir_q), 32'(m_ir));
        sel_cnt = $countones({bus_if.r_out, bus_if.din_out, bus_if.g_out});
        check({tag, "_bus_onehot"}, 32'(sel_cnt <= 1), 32'd1);
        if (sel_cnt != 0)
            check({tag, "_sel_has_sink"},
                  32'(bus_if.done || (bus_if.r_in != 0) || bus_if.a_in || bus_if.g_in), 32'd1);
        if (bus_if.done === 1'b1) done_log.push_back(cyc);
        if (rst_i) begin
            plan_q.delete();
            m_ir     = '0;
            ir_known = 1'b1;
        end else if (plan_q.size() == 0) begin
            if (run_i) begin
                m_ir       = din_i[8:0];
                accept_cyc = cyc;
                plan(m_ir);
            end
        end else begin
            void'(plan_q.pop_front());
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [8:0] prog[3];
        int         idx;
        int         base;
        int         exp_done[3];

        reset       = 1'b1;
        bus_if.run  = 1'b0;
        bus_if.din  = '0;
        bus_if.g_nz = 1'b0;
        @(posedge clock);
        #1;

        // Reset then idle: nothing enabled, ir_q cleared.
        repeat (2) cycle("reset", 1'b1, 1'b0, 16'(16'hFFFF), 1'b1);
        repeat (10) cycle("idle", 1'b0, 1'b0, 16'($urandom), 1'($urandom));

        // mvi R2,#00A5
        cycle("mvi_t0", 1'b0, 1'b1, 16'({7'd0, 9'b001_010_000}), 1'b0);
        cycle("mvi_t1", 1'b0, 1'b0, 16'h00A5, 1'b0);
        cycle("mvi_t0b", 1'b0, 1'b0, 16'h0000, 1'b0);

        // add R1,R2 with latency from acceptance to done.
        done_log.delete();
        cycle("add_t0", 1'b0, 1'b1, 16'({7'd0, 9'b010_001_010}), 1'b0);
        cycle("add_t1", 1'b0, 1'b1, 16'($urandom), 1'b0);
        cycle("add_t2", 1'b0, 1'b1, 16'($urandom), 1'b1);
        cycle("add_t3", 1'b0, 1'b0, 16'($urandom), 1'b0);
        check("add_done_seen", 32'(done_log.size()), 32'd1);
        if (done_log.size() != 0) check("add_latency", 32'(done_log[0] - accept_cyc + 1), 32'd4);

        // mvnz R0,R7 with G zero and non-zero.
        cycle("mvnz0_t0", 1'b0, 1'b1, 16'({7'd0, 9'b111_000_111}), 1'b0);
        cycle("mvnz0_t1", 1'b0, 1'b0, 16'h0000, 1'b0);
        cycle("mvnz1_t0", 1'b0, 1'b1, 16'({7'd0, 9'b111_000_111}), 1'b1);
        cycle("mvnz1_t1", 1'b0, 1'b0, 16'h0000, 1'b1);

        // Reset during T2 of sub R5,R6, then a fresh instruction.
        cycle("sub_t0", 1'b0, 1'b1, 16'({7'd0, 9'b011_101_110}), 1'b0);
        cycle("sub_t1", 1'b0, 1'b0, 16'($urandom), 1'b0);
        cycle("sub_rst", 1'b1, 1'b0, 16'($urandom), 1'b0);
        cycle("post_rst", 1'b0, 1'b0, 16'($urandom), 1'b0);
        cycle("or_t0", 1'b0, 1'b1, 16'({7'd0, 9'b101_110_011}), 1'b0);
        repeat (3) cycle("or_run", 1'b0, 1'b0, 16'($urandom), 1'b0);

        // Back-to-back mv, slt, mvi with run held high.
        prog[0] = 9'b000_011_101;
        prog[1] = 9'b110_001_010;
        prog[2] = 9'b001_100_000;
        exp_done[0] = 2;
        exp_done[1] = 6;
        exp_done[2] = 8;
        idx  = 0;
        base = cyc;
        done_log.delete();
        for (int k = 0; k < 8; k++) begin
            if (plan_q.size() == 0 && idx < 3) begin
                cycle("b2b", 1'b0, 1'b1, 16'(prog[idx]), 1'b0);
                idx++;
            end else begin
                cycle("b2b", 1'b0, 1'b1, 16'($urandom), 1'b0);
            end
        end
        cycle("b2b_end", 1'b0, 1'b0, 16'($urandom), 1'b0);
        check("b2b_done_count", 32'(done_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < done_log.size(); i++)
            check($sformatf("b2b_done%0d", i), 32'(done_log[i] - base), 32'(exp_done[i]));

        // Random traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            cycle("rand", 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0),
                  16'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
